// File: rtl/sync_fifo_param_pkg.sv
// Shared constants, read-mode enum and sizing helper for the parameterised FIFO.
package fifo_pkg;
  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;

  typedef enum logic {FIFO_STD = 1'b0, FIFO_FWFT = 1'b1} fifo_mode_e;

  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of the FIFO; the FIFO itself takes the slave side.
interface sync_fifo_if #(
  parameter int WIDTH = fifo_pkg::FIFO_WIDTH,
  parameter int DEPTH = fifo_pkg::FIFO_DEPTH
);
  import fifo_pkg::*;
  localparam int CW = fifo_aw(DEPTH) + 1;

  logic             flush;
  logic             w_en;
  logic [WIDTH-1:0] data_in;
  logic             r_en;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, w_en, data_in, r_en,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, w_en, data_in, r_en,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_mem.sv
// Width x Depth storage: synchronous write, asynchronous read, contents never reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int Width = FIFO_WIDTH,
  parameter int Depth = FIFO_DEPTH,
  parameter int AW    = fifo_aw(Depth)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);
  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: pointers, occupancy, threshold/error flags, flush and the
// standard (registered) or first-word-fall-through read path.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int Width    = FIFO_WIDTH,
  parameter int Depth    = FIFO_DEPTH,
  parameter int AfullTh  = 14,
  parameter int AemptyTh = 2,
  parameter int Fwft     = 0
) (
  input logic       clk,
  input logic       rst_n,
  sync_fifo_if.slave bus
);
  localparam int AW = fifo_aw(Depth);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             full, empty, wr_ok, rd_ok;
  logic [Width-1:0] mem_rdata;

  assign full  = (cnt_q == CW'(Depth));
  assign empty = (cnt_q == '0);
  // flush swallows both requests so nothing is stored or popped that cycle
  assign wr_ok = bus.w_en && !full  && !bus.flush;
  assign rd_ok = bus.r_en && !empty && !bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_ok && !rd_ok)      cnt_d = cnt_q + CW'(1);
      else if (rd_ok && !wr_ok) cnt_d = cnt_q - CW'(1);
      if (bus.w_en && full)  ovf_d = 1'b1;
      if (bus.r_en && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(.Width(Width), .Depth(Depth), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  generate
    if (Fwft == 0) begin : g_std
      logic [Width-1:0] dout_q, dout_d;
      always_comb begin
        dout_d = dout_q;
        if (rd_ok) dout_d = mem_rdata;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
      end
      assign bus.data_out = dout_q;
    end else begin : g_fwft
      // head word is presented as soon as it lands; zero while empty
      assign bus.data_out = empty ? '0 : mem_rdata;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt_q >= CW'(AfullTh));
  assign bus.almost_empty = (cnt_q <= CW'(AemptyTh));
  assign bus.count        = cnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule
